// File: rtl/tone_burst_reg_bank_mc.sv
// Double-buffered multi-channel register bank for the tone burst oscillator.
// Host writes land in per-channel shadow registers. The active copy seen by
// each channel's state machine is replaced all at once, either on a commit
// or at the channel's burst boundary. The bus side has a registered response
// with an error flag, per-channel write-1-to-clear interrupt flags and a
// masked, registered irq.
module tone_burst_reg_bank_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int DUTY_MAX   = 1024,
  localparam int ADDR_WIDTH = $clog2(NUM_CH) + 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         bus_valid_i,
  input  logic                         bus_write_i,
  input  logic [ADDR_WIDTH-1:0]        bus_addr_i,
  input  logic [DATA_WIDTH-1:0]        bus_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      bus_wstrb_i,
  output logic [DATA_WIDTH-1:0]        bus_rdata_o,
  output logic                         bus_rvalid_o,
  output logic                         bus_err_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_pulse_count_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_burst_count_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_duty_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_ibd_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_period_o,
  output logic [NUM_CH-1:0]            ch_enable_o,
  output logic [NUM_CH-1:0]            ch_trigger_o,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_status_in_i,
  input  logic [NUM_CH-1:0]            ch_boundary_i,
  input  logic [NUM_CH-1:0]            ch_burst_done_i,
  input  logic [NUM_CH-1:0]            ch_seq_done_i,
  output logic                         irq_o
);

  localparam int DW   = DATA_WIDTH;
  localparam int NB   = DATA_WIDTH / 8;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Shadowed registers, stored at index reg_idx-1:
  // 0 PULSE_CNT, 1 BURST_CNT, 2 DUTY, 3 IBD, 4 PERIOD.
  localparam int NREG = 5;

  logic [DW-1:0] shadow_q [NUM_CH][NREG];
  logic [DW-1:0] shadow_d [NUM_CH][NREG];
  logic [DW-1:0] active_q [NUM_CH][NREG];
  logic [DW-1:0] active_d [NUM_CH][NREG];
  logic [1:0]    mask_q   [NUM_CH];
  logic [1:0]    mask_d   [NUM_CH];
  logic [1:0]    flags_q  [NUM_CH];
  logic [1:0]    flags_d  [NUM_CH];
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [NUM_CH-1:0] trigger_q, trigger_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic              irq_q, irq_d;
  logic              rvalid_q;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [2:0]     regIdx;
  logic [CHW-1:0] chIdx;
  logic           wrAccess;
  logic [DW-1:0]  statusCh [NUM_CH];

  assign regIdx   = bus_addr_i[2:0];
  assign wrAccess = bus_valid_i & bus_write_i;

  if (NUM_CH > 1) begin : gChSel
    assign chIdx = bus_addr_i[ADDR_WIDTH-1:3];
  end else begin : gChOne
    assign chIdx = '0;
  end

  // Reset values of the shadowed registers, in storage order.
  function automatic logic [DW-1:0] regDefault(input int r);
    case (r)
      0:       return DW'(10);
      1:       return DW'(5);
      2:       return DW'(512);
      3:       return DW'(1000);
      default: return DW'(100);
    endcase
  endfunction

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [DW-1:0] byteMerge(input logic [DW-1:0] oldVal,
                                              input logic [DW-1:0] newVal,
                                              input logic [NB-1:0] strb);
    logic [DW-1:0] res;
    res = oldVal;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[b*8 +: 8] = newVal[b*8 +: 8];
    end
    return res;
  endfunction

  // Duty is clamped to the ceiling; counts and period of zero would stall
  // the oscillator, so they are stored as one.
  function automatic logic [DW-1:0] sanitize(input int r, input logic [DW-1:0] v);
    if (r == 2 && v > DW'(DUTY_MAX)) return DW'(DUTY_MAX);
    if ((r == 0 || r == 1 || r == 4) && v == '0) return DW'(1);
    return v;
  endfunction

  // CTRL as seen by the host: trigger and commit are actions and read back 0.
  function automatic logic [DW-1:0] ctrlWord(input logic en, input logic [1:0] m);
    logic [DW-1:0] w;
    w      = '0;
    w[0]   = en;
    w[9:8] = m;
    return w;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : gChan
    assign statusCh[c]                    = ch_status_in_i[c*DW +: DW];
    assign ch_pulse_count_o[c*DW +: DW]   = active_q[c][0];
    assign ch_burst_count_o[c*DW +: DW]   = active_q[c][1];
    assign ch_duty_o[c*DW +: DW]          = active_q[c][2];
    assign ch_ibd_o[c*DW +: DW]           = active_q[c][3];
    assign ch_period_o[c*DW +: DW]        = active_q[c][4];
  end

  // Next state of every channel: host writes, event flags, and shadow->active copy.
  always_comb begin : nextState
    logic          wrHit;
    logic          doCommit;
    logic [1:0]    clearBits;
    logic [DW-1:0] merged;
    shadow_d  = shadow_q;
    active_d  = active_q;
    mask_d    = mask_q;
    flags_d   = flags_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    trigger_d = '0;
    irq_d     = 1'b0;
    wrHit     = 1'b0;
    doCommit  = 1'b0;
    clearBits = 2'b00;
    merged    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wrHit     = wrAccess && (chIdx == CHW'(c));
      doCommit  = 1'b0;
      clearBits = 2'b00;
      merged    = '0;
      if (wrHit) begin
        if (regIdx == 3'd0) begin
          merged       = byteMerge(ctrlWord(enable_q[c], mask_q[c]), bus_wdata_i, bus_wstrb_i);
          enable_d[c]  = merged[0];
          trigger_d[c] = merged[1];
          doCommit     = merged[2];
          mask_d[c]    = merged[9:8];
        end else if (regIdx == 3'd7) begin
          merged    = byteMerge('0, bus_wdata_i, bus_wstrb_i);
          clearBits = merged[1:0];
        end else if (|bus_wstrb_i) begin
          for (int r = 0; r < NREG; r++) begin
            if (regIdx == 3'(r + 1)) begin
              merged         = byteMerge(shadow_q[c][r], bus_wdata_i, bus_wstrb_i);
              shadow_d[c][r] = sanitize(r, merged);
              pending_d[c]   = 1'b1;
            end
          end
        end
      end
      flags_d[c] = (flags_q[c] & ~clearBits) | {ch_seq_done_i[c], ch_burst_done_i[c]};
      if (doCommit || (pending_q[c] && ch_boundary_i[c])) begin
        active_d[c]  = shadow_d[c];
        pending_d[c] = 1'b0;
      end
      irq_d = irq_d | (|(flags_d[c] & mask_d[c]));
    end
  end

  // Response payload for the current access: read mux or STATUS-write error.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (bus_valid_i) begin
      if (bus_write_i) begin
        err_d = (regIdx == 3'd6);
      end else begin
        case (regIdx)
          3'd0:    rdata_d = ctrlWord(enable_q[chIdx], mask_q[chIdx]);
          3'd6:    rdata_d = statusCh[chIdx];
          3'd7:    rdata_d = DW'(flags_q[chIdx]);
          default: begin
            for (int r = 0; r < NREG; r++) begin
              if (regIdx == 3'(r + 1)) rdata_d = shadow_q[chIdx][r];
            end
          end
        endcase
      end
    end
  end

  // Register bank state; reset restores every channel's defaults at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int r = 0; r < NREG; r++) begin
          shadow_q[c][r] <= regDefault(r);
          active_q[c][r] <= regDefault(r);
        end
        mask_q[c]  <= 2'b00;
        flags_q[c] <= 2'b00;
      end
      enable_q  <= '0;
      trigger_q <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      mask_q    <= mask_d;
      flags_q   <= flags_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  // Bus response one cycle after each access; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus_valid_i;
      err_q    <= err_d;
      if (bus_valid_i) rdata_q <= rdata_d;
    end
  end

  assign bus_rdata_o  = rdata_q;
  assign bus_rvalid_o = rvalid_q;
  assign bus_err_o    = err_q;
  assign ch_enable_o  = enable_q;
  assign ch_trigger_o = trigger_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_tone_burst_reg_bank_mc.sv
// Bench for the tone burst register bank: a behavioural model of the register
// map tracks what every output must be, a compare process checks it each
// cycle, and directed sequences pin key values against hand-computed literals.
module tb_tone_burst_reg_bank_mc;

  logic          clk;
  logic          rst_n;
  logic          busValid;
  logic          busWrite;
  logic [4:0]    busAddr;
  logic [31:0]   busWdata;
  logic [3:0]    busWstrb;
  logic [31:0]   busRdata;
  logic          busRvalid;
  logic          busErr;
  logic [127:0]  chPulseCount;
  logic [127:0]  chBurstCount;
  logic [127:0]  chDuty;
  logic [127:0]  chIbd;
  logic [127:0]  chPeriod;
  logic [3:0]    chEnable;
  logic [3:0]    chTrigger;
  logic [127:0]  chStatusIn;
  logic [3:0]    chBoundary;
  logic [3:0]    chBurstDone;
  logic [3:0]    chSeqDone;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Model state: registers indexed by reg_idx directly (1..5 used).
  int unsigned mShadow [4][8];
  int unsigned mActive [4][8];
  bit          mEn     [4];
  bit          mTrig   [4];
  bit          mPend   [4];
  bit [1:0]    mMask   [4];
  bit [1:0]    mFlags  [4];
  bit          mIrq;
  bit          mRvalid;
  bit          mErr;
  logic [31:0] mRdata;

  tone_burst_reg_bank_mc dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .bus_valid_i      (busValid),
    .bus_write_i      (busWrite),
    .bus_addr_i       (busAddr),
    .bus_wdata_i      (busWdata),
    .bus_wstrb_i      (busWstrb),
    .bus_rdata_o      (busRdata),
    .bus_rvalid_o     (busRvalid),
    .bus_err_o        (busErr),
    .ch_pulse_count_o (chPulseCount),
    .ch_burst_count_o (chBurstCount),
    .ch_duty_o        (chDuty),
    .ch_ibd_o         (chIbd),
    .ch_period_o      (chPeriod),
    .ch_enable_o      (chEnable),
    .ch_trigger_o     (chTrigger),
    .ch_status_in_i   (chStatusIn),
    .ch_boundary_i    (chBoundary),
    .ch_burst_done_i  (chBurstDone),
    .ch_seq_done_i    (chSeqDone),
    .irq_o            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] chField(input logic [127:0] v, input int c);
    return v[c*32 +: 32];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    int unsigned defs [8];
    defs = '{0, 10, 5, 512, 1000, 100, 0, 0};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) begin
        mShadow[c][r] = defs[r];
        mActive[c][r] = defs[r];
      end
      mEn[c] = 0; mTrig[c] = 0; mPend[c] = 0; mMask[c] = 0; mFlags[c] = 0;
    end
    mIrq = 0; mRvalid = 0; mErr = 0; mRdata = 0;
  endtask

  // One clock of the register map rules, applied to the inputs present at the edge.
  task automatic modelStep();
    int          ch;
    int          idx;
    bit          pendBefore [4];
    bit          commitNow  [4];
    bit [1:0]    clr        [4];
    logic [31:0] v;
    ch  = int'(busAddr[4:3]);
    idx = int'(busAddr[2:0]);
    mRvalid = busValid;
    mErr    = busValid && busWrite && idx == 6;
    mRdata  = 0;
    if (busValid && !busWrite) begin
      if (idx == 0)      mRdata = {22'b0, mMask[ch], 7'b0, mEn[ch]};
      else if (idx == 6) mRdata = chStatusIn[ch*32 +: 32];
      else if (idx == 7) mRdata = {30'b0, mFlags[ch]};
      else               mRdata = mShadow[ch][idx];
    end
    for (int c = 0; c < 4; c++) begin
      pendBefore[c] = mPend[c];
      commitNow[c]  = 0;
      clr[c]        = 0;
      mTrig[c]      = 0;
    end
    if (busValid && busWrite) begin
      if (idx == 0) begin
        if (busWstrb[0]) begin
          mEn[ch]       = busWdata[0];
          mTrig[ch]     = busWdata[1];
          commitNow[ch] = busWdata[2];
        end
        if (busWstrb[1]) mMask[ch] = busWdata[9:8];
      end else if (idx >= 1 && idx <= 5 && busWstrb != 0) begin
        v = mShadow[ch][idx];
        for (int b = 0; b < 4; b++) if (busWstrb[b]) v[8*b +: 8] = busWdata[8*b +: 8];
        if (idx == 3 && v > 1024) v = 1024;
        if ((idx == 1 || idx == 2 || idx == 5) && v == 0) v = 1;
        mShadow[ch][idx] = v;
        mPend[ch] = 1;
      end else if (idx == 7 && busWstrb[0]) begin
        clr[ch] = busWdata[1:0];
      end
    end
    mIrq = 0;
    for (int c = 0; c < 4; c++) begin
      mFlags[c] = (mFlags[c] & ~clr[c]) | {chSeqDone[c], chBurstDone[c]};
      if (commitNow[c] || (pendBefore[c] && chBoundary[c])) begin
        for (int r = 1; r <= 5; r++) mActive[c][r] = mShadow[c][r];
        mPend[c] = 0;
      end
      if ((mFlags[c] & mMask[c]) != 0) mIrq = 1;
    end
  endtask

  // Model advances on every clock, and returns to defaults the moment reset asserts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rvalid", 32'(busRvalid), 32'(mRvalid));
      if (mRvalid) begin
        checkOutput("err", 32'(busErr), 32'(mErr));
        checkOutput("rdata", busRdata, mRdata);
      end
      checkOutput("irq", 32'(irq), 32'(mIrq));
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("trigger[%0d]", c), 32'(chTrigger[c]), 32'(mTrig[c]));
        checkOutput($sformatf("enable[%0d]", c), 32'(chEnable[c]), 32'(mEn[c]));
        checkOutput($sformatf("pulse_count[%0d]", c), chField(chPulseCount, c), mActive[c][1]);
        checkOutput($sformatf("burst_count[%0d]", c), chField(chBurstCount, c), mActive[c][2]);
        checkOutput($sformatf("duty[%0d]", c), chField(chDuty, c), mActive[c][3]);
        checkOutput($sformatf("ibd[%0d]", c), chField(chIbd, c), mActive[c][4]);
        checkOutput($sformatf("period[%0d]", c), chField(chPeriod, c), mActive[c][5]);
      end
    end
  end

  // Drive one cycle of inputs, then return just after the response edge.
  task automatic applyStimulus(input logic v, input logic w, input int ch, input int idx,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [3:0] bnd, input logic [3:0] bd, input logic [3:0] sd);
    @(posedge clk); #1;
    busValid = v; busWrite = w; busAddr = {2'(ch), 3'(idx)};
    busWdata = d; busWstrb = s;
    chBoundary = bnd; chBurstDone = bd; chSeqDone = sd;
    @(posedge clk); #1;
    busValid = 0; busWrite = 0; busWdata = 0; busWstrb = 0;
    chBoundary = 0; chBurstDone = 0; chSeqDone = 0;
  endtask

  task automatic busWrite_(input int ch, input int idx, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(1, 1, ch, idx, d, s, 0, 0, 0);
  endtask

  task automatic busRead(input int ch, input int idx, output logic [31:0] d, output logic e);
    applyStimulus(1, 0, ch, idx, 0, 0, 0, 0, 0);
    checkOutput("read rvalid", 32'(busRvalid), 1);
    d = busRdata;
    e = busErr;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] expCh0 [8];
    expCh0 = '{32'd0, 32'd10, 32'd5, 32'd512, 32'd1000, 32'd100, 32'h5A00_0000, 32'd0};
    busValid = 0; busWrite = 0; busAddr = 0; busWdata = 0; busWstrb = 0;
    chBoundary = 0; chBurstDone = 0; chSeqDone = 0;
    for (int c = 0; c < 4; c++) chStatusIn[c*32 +: 32] = 32'h5A00_0000 | 32'(c);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    $display("[TB] reset defaults");
    checkOutput("reset rvalid", 32'(busRvalid), 0);
    checkOutput("reset irq", 32'(irq), 0);
    checkOutput("reset trigger", 32'(chTrigger), 0);
    checkOutput("reset pulse ch0", chField(chPulseCount, 0), 10);
    checkOutput("reset burst ch0", chField(chBurstCount, 0), 5);
    checkOutput("reset duty ch3", chField(chDuty, 3), 512);
    checkOutput("reset ibd ch2", chField(chIbd, 2), 1000);
    checkOutput("reset period ch1", chField(chPeriod, 1), 100);
    @(negedge clk); #1 rst_n = 1;

    $display("[TB] read all registers of ch0");
    for (int i = 0; i < 8; i++) begin
      busRead(0, i, rd, er);
      checkOutput($sformatf("ch0 reg%0d", i), rd, expCh0[i]);
      checkOutput($sformatf("ch0 reg%0d err", i), 32'(er), 0);
    end

    $display("[TB] shadow held until boundary");
    busWrite_(2, 1, 20, 4'hF);
    checkOutput("ch2 pulse before boundary", chField(chPulseCount, 2), 10);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100, 0, 0);
    checkOutput("ch2 pulse after boundary", chField(chPulseCount, 2), 20);

    $display("[TB] clamp, zero fix-up and byte strobes");
    busWrite_(1, 3, 2000, 4'hF);
    busRead(1, 3, rd, er);
    checkOutput("duty clamp", rd, 1024);
    busWrite_(1, 2, 0, 4'hF);
    busRead(1, 2, rd, er);
    checkOutput("burst zero->1", rd, 1);
    busWrite_(1, 5, 32'h1234_5678, 4'hF);
    busWrite_(1, 5, 32'h0000_00AB, 4'b0001);
    busRead(1, 5, rd, er);
    checkOutput("byte merge", rd, 32'h1234_56AB);
    busWrite_(1, 0, 32'h4, 4'hF);
    checkOutput("ch1 commit duty", chField(chDuty, 1), 1024);
    checkOutput("ch1 commit burst", chField(chBurstCount, 1), 1);
    checkOutput("ch1 commit period", chField(chPeriod, 1), 32'h1234_56AB);

    $display("[TB] trigger plus commit");
    busWrite_(3, 3, 300, 4'hF);
    checkOutput("ch3 duty pending", chField(chDuty, 3), 512);
    busWrite_(3, 0, 32'h6, 4'hF);
    checkOutput("ch3 trigger pulse", 32'(chTrigger), 32'b1000);
    checkOutput("ch3 duty committed", chField(chDuty, 3), 300);
    @(posedge clk); #1;
    checkOutput("ch3 trigger ends", 32'(chTrigger), 0);
    busRead(3, 0, rd, er);
    checkOutput("ch3 ctrl readback", rd, 0);

    $display("[TB] zero strobe write and write-through copy");
    busWrite_(0, 3, 32'h55, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    checkOutput("ch0 duty after nop", chField(chDuty, 0), 512);
    busWrite_(2, 1, 7, 4'hF);
    applyStimulus(1, 1, 2, 1, 9, 4'hF, 4'b0100, 0, 0);
    checkOutput("ch2 write-through", chField(chPulseCount, 2), 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100, 0, 0);

    $display("[TB] interrupts");
    busWrite_(0, 0, 32'h101, 4'h3);
    checkOutput("ch0 enable", 32'(chEnable), 32'b0001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0001, 0);
    checkOutput("irq on burst_done", 32'(irq), 1);
    applyStimulus(1, 1, 0, 7, 32'h1, 4'b0001, 0, 4'b0001, 0);
    checkOutput("irq set beats clear", 32'(irq), 1);
    busRead(0, 7, rd, er);
    checkOutput("flags after race", rd, 1);
    busWrite_(0, 7, 32'h1, 4'b0001);
    checkOutput("irq after W1C", 32'(irq), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
    checkOutput("irq masked seq_done", 32'(irq), 0);
    busRead(0, 7, rd, er);
    checkOutput("flags seq_done", rd, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0001, 0);

    $display("[TB] status write error and status read");
    applyStimulus(1, 1, 2, 6, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    checkOutput("status write err", 32'(busErr), 1);
    busRead(2, 6, rd, er);
    checkOutput("status read", rd, 32'h5A00_0002);
    checkOutput("status read err", 32'(er), 0);

    $display("[TB] asynchronous reset mid-sequence");
    @(posedge clk); #1;
    busValid = 1; busWrite = 0; busAddr = {2'd1, 3'd3};
    @(posedge clk); #1;
    busValid = 0;
    checkOutput("in-flight rvalid", 32'(busRvalid), 1);
    checkOutput("irq before reset", 32'(irq), 1);
    #1 rst_n = 0;
    #1;
    checkOutput("async rvalid", 32'(busRvalid), 0);
    checkOutput("async irq", 32'(irq), 0);
    checkOutput("async enable", 32'(chEnable), 0);
    checkOutput("async duty ch1", chField(chDuty, 1), 512);
    checkOutput("async pulse ch2", chField(chPulseCount, 2), 10);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1;
    busRead(1, 3, rd, er);
    checkOutput("shadow duty after reset", rd, 512);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
